// File: rtl/ray_pkg.sv
// Shared types and constants for the ray row scheduler: scheduler states,
// Q8.8 distance type and the line-buffer entry layout.
package ray_pkg;

    localparam int H_VISIBLE       = 640;
    localparam int H_CENTER        = 320;
    localparam int V_CENTER        = 240;
    localparam int MAX_OUTSTANDING = 8;
    localparam int T_W             = 16;
    localparam int DIR_W           = 16;

    typedef logic signed [T_W-1:0] q8_8_t;

    typedef struct packed {
        logic  hit;
        q8_8_t t;
    } lb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } sched_state_t;

    // Signed difference of two 10-bit screen coordinates, widened to a ray component.
    function automatic logic [DIR_W-1:0] dir_offset(input logic [9:0] a, input logic [9:0] b);
        return {6'd0, a} - {6'd0, b};
    endfunction

endpackage

// File: rtl/ray_row_scheduler_if.sv
// Bundle of the row-command, ray-issue, result and line-buffer signals.
// Handshakes: a transfer happens on a clock edge where valid && ready; the
// sender holds payload stable while valid && !ready. result_valid has no ready.
interface ray_row_scheduler_if;
    import ray_pkg::*;

    logic               row_valid;
    logic               row_ready;
    logic [9:0]         row_y;
    logic               abort;
    logic               issue_valid;
    logic               issue_ready;
    logic signed [15:0] issue_dir_x;
    logic signed [15:0] issue_dir_y;
    logic               result_valid;
    logic               result_hit;
    logic [T_W-1:0]     result_t;
    logic               wr_en;
    logic [10:0]        wr_addr;
    logic [T_W:0]       wr_data;
    logic               row_done;
    logic               row_done_bank;
    logic               busy;
    logic               err_spurious;
    sched_state_t       state_dbg;

    modport master (
        input  row_valid, row_y, abort, issue_ready, result_valid, result_hit, result_t,
        output row_ready, issue_valid, issue_dir_x, issue_dir_y, wr_en, wr_addr, wr_data,
               row_done, row_done_bank, busy, err_spurious, state_dbg
    );

    modport slave (
        output row_valid, row_y, abort, issue_ready, result_valid, result_hit, result_t,
        input  row_ready, issue_valid, issue_dir_x, issue_dir_y, wr_en, wr_addr, wr_data,
               row_done, row_done_bank, busy, err_spurious, state_dbg
    );

endinterface

// File: rtl/ray_credit_counter.sv
// Up/down count of rays in flight in the intersection pipeline, saturating
// at MAX and never going below zero.
module ray_credit_counter
    import ray_pkg::*;
#(
    parameter int MAX = MAX_OUTSTANDING
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic zero_next
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] count_q, count_d;
    logic         up, dn;

    always_comb begin
        up      = inc && (count_q != W'(MAX));
        dn      = dec && (count_q != '0);
        count_d = count_q;
        if (up && !dn) begin
            count_d = count_q + W'(1);
        end else if (!up && dn) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full      = (count_q == W'(MAX));
    assign empty     = (count_q == '0);
    assign zero_next = (count_d == '0);

endmodule

// File: rtl/ray_row_scheduler.sv
// Issues one ray per visible pixel of a row to the shared intersection unit
// under a credit limit, and writes the in-order results into a ping-pong line buffer.
module ray_row_scheduler
    import ray_pkg::*;
#(
    parameter int P_H_VISIBLE       = H_VISIBLE,
    parameter int P_H_CENTER        = H_CENTER,
    parameter int P_V_CENTER        = V_CENTER,
    parameter int P_MAX_OUTSTANDING = MAX_OUTSTANDING
) (
    input logic                 clock,
    input logic                 reset,
    ray_row_scheduler_if.master bus
);
    localparam logic [9:0] LAST_X = 10'(P_H_VISIBLE - 1);

    sched_state_t state_q, state_d;
    logic [9:0]   x_q, x_d, rx_q, rx_d, y_q, y_d;
    logic         bank_q, bank_d;
    logic         err_q, err_d;
    logic         wr_en_q, wr_en_d;
    logic [10:0]  wr_addr_q, wr_addr_d;
    lb_entry_t    wr_data_q, wr_data_d;
    logic         row_done_q, row_done_d;
    logic         done_bank_q, done_bank_d;

    logic issue_valid_c, row_ready_c, issue_hs, capture;
    logic full, empty, zero_next;

    ray_credit_counter #(.MAX(P_MAX_OUTSTANDING)) u_credit (
        .clock     (clock),
        .reset     (reset),
        .inc       (issue_hs),
        .dec       (bus.result_valid),
        .full      (full),
        .empty     (empty),
        .zero_next (zero_next)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        rx_d        = rx_q;
        y_d         = y_q;
        bank_d      = bank_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_bank_d = done_bank_q;
        row_ready_c = 1'b0;

        issue_valid_c = (state_q == ISSUE) && !full;
        issue_hs      = issue_valid_c && bus.issue_ready;
        // A result landing in the abort cycle belongs to the dropped row.
        capture       = bus.result_valid && !empty && !bus.abort &&
                        ((state_q == ISSUE) || (state_q == DRAIN));
        err_d         = err_q || (bus.result_valid && empty);

        wr_en_d    = capture;
        row_done_d = capture && (rx_q == LAST_X);
        if (capture) begin
            wr_addr_d   = {bank_q, rx_q};
            wr_data_d   = '{hit: bus.result_hit, t: bus.result_t};
            done_bank_d = bank_q;
            rx_d        = rx_q + 10'd1;
        end

        case (state_q)
            IDLE: begin
                row_ready_c = 1'b1;
                if (bus.row_valid) begin
                    y_d     = bus.row_y;
                    bank_d  = !bank_q;
                    x_d     = '0;
                    rx_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_hs) begin
                    x_d = x_q + 10'd1;
                end
                if (bus.abort) begin
                    state_d = FLUSH;
                end else if (issue_hs && (x_q == LAST_X)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the cycle the final write is visible so row_ready follows it.
                if (bus.abort) begin
                    state_d = FLUSH;
                end else if (row_done_q) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (zero_next) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            rx_q        <= '0;
            y_q         <= '0;
            bank_q      <= 1'b1;
            err_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            row_done_q  <= 1'b0;
            done_bank_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            rx_q        <= rx_d;
            y_q         <= y_d;
            bank_q      <= bank_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            row_done_q  <= row_done_d;
            done_bank_q <= done_bank_d;
        end
    end

    assign bus.row_ready     = row_ready_c;
    assign bus.issue_valid   = issue_valid_c;
    assign bus.issue_dir_x   = issue_valid_c ? dir_offset(x_q, 10'(P_H_CENTER)) : '0;
    assign bus.issue_dir_y   = issue_valid_c ? dir_offset(10'(P_V_CENTER), y_q) : '0;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data       = wr_data_q;
    assign bus.row_done      = row_done_q;
    assign bus.row_done_bank = done_bank_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.err_spurious  = err_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_ray_row_scheduler.sv
// Directed bench for ray_row_scheduler with a fixed-latency intersection model
// and a write scoreboard.
module tb_ray_row_scheduler;
    import ray_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ray_row_scheduler_if bus();

    ray_row_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic        hit;
        logic [15:0] t;
    } res_t;

    int          checks = 0;
    int          errors = 0;
    logic [27:0] exp_q[$];
    res_t        pend_q[$];

    int          cyc = 0;
    int          lat = 3;
    bit          rand_ready = 1'b0;
    int          hs_row = 0;
    int          model_out = 0;
    int          max_out = 0;
    logic        exp_bank = 1'b1;
    int          exp_rx = 0;
    logic [15:0] exp_dir_y = '0;
    bit          flushing = 1'b0;
    int          abort_at = -1;
    bit          abort_done = 1'b0;
    int          flush_res = 0;
    int          flush_wr = 0;
    int          done_count = 0;
    int          writes_row = 0;
    bit          force_spur = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_dir_x = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Environment: monitors outputs, then drives intersection-unit inputs for the next edge.
    always @(negedge clock) begin
        res_t        r;
        bit          got_res;
        bit          hs;
        bit          was_flushing;
        int          x;
        cyc++;
        was_flushing = flushing;

        if (bus.wr_en === 1'b1) begin
            writes_row++;
            if (flushing) flush_wr++;
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("write_entry", {4'h0, bus.wr_addr, bus.wr_data}, {4'h0, exp_q.pop_front()});
        end
        if (bus.row_done === 1'b1) begin
            done_count++;
            chk("row_done_bank", 32'(bus.row_done_bank), 32'(exp_bank));
            chk("row_done_last_addr", {21'd0, bus.wr_en, bus.wr_addr[9:0]}, {21'd0, 1'b1, 10'd639});
        end
        if (model_out >= MAX_OUTSTANDING) chk("issue_valid_when_full", 32'(bus.issue_valid), 32'd0);
        if (prev_stall) begin
            chk("stall_valid_held", 32'(bus.issue_valid), 32'd1);
            chk("stall_dir_x_held", {16'h0, bus.issue_dir_x}, {16'h0, prev_dir_x});
        end

        got_res           = 1'b0;
        bus.result_valid  = 1'b0;
        bus.result_hit    = 1'b0;
        bus.result_t      = '0;
        if (force_spur) begin
            bus.result_valid = 1'b1;
            force_spur       = 1'b0;
        end else if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
            r                = pend_q.pop_front();
            got_res          = 1'b1;
            bus.result_valid = 1'b1;
            bus.result_hit   = r.hit;
            bus.result_t     = r.t;
            model_out--;
        end

        bus.issue_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        hs = (bus.issue_valid === 1'b1) && bus.issue_ready;
        bus.abort = 1'b0;
        if (hs) begin
            x = hs_row;
            chk("handshake_in_row", 32'(x < H_VISIBLE), 32'd1);
            chk("issue_dir_x", {16'h0, bus.issue_dir_x}, {16'h0, 16'(x - H_CENTER)});
            chk("issue_dir_y", {16'h0, bus.issue_dir_y}, {16'h0, exp_dir_y});
            pend_q.push_back('{due: cyc + lat, hit: x[0] ^ x[2], t: 16'(x * 37 - 9000)});
            hs_row++;
            model_out++;
            if (model_out > max_out) max_out = model_out;
            if (abort_at >= 0 && !abort_done && hs_row == abort_at) begin
                bus.abort  = 1'b1;
                abort_done = 1'b1;
                flushing   = 1'b1;
            end
        end

        if (got_res) begin
            if (was_flushing) begin
                flush_res++;
            end else if (!flushing) begin
                exp_q.push_back({exp_bank, 10'(exp_rx), r.hit, r.t});
                exp_rx++;
            end
        end

        prev_stall = hs ? 1'b0 : ((bus.issue_valid === 1'b1) && !bus.issue_ready);
        prev_dir_x = bus.issue_dir_x;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic start_row(input logic [9:0] y);
        chk("row_ready_before_row", 32'(bus.row_ready), 32'd1);
        exp_bank   = !exp_bank;
        exp_rx     = 0;
        hs_row     = 0;
        writes_row = 0;
        max_out    = 0;
        exp_dir_y  = 16'(V_CENTER - int'(y));
        bus.row_y     = y;
        bus.row_valid = 1'b1;
        step();
        bus.row_valid = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("row_ready_after_accept", 32'(bus.row_ready), 32'd0);
        chk("first_issue_valid", 32'(bus.issue_valid), 32'd1);
    endtask

    task automatic finish_row(input int budget, input int done_before);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (bus.row_done === 1'b1) seen = 1'b1;
        end
        chk("row_done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("row_ready_with_done", 32'(bus.row_ready), 32'd0);
            step();
            chk("row_ready_after_done", 32'(bus.row_ready), 32'd1);
            chk("busy_after_done", 32'(bus.busy), 32'd0);
        end
        chk("row_handshakes", 32'(hs_row), 32'(H_VISIBLE));
        chk("row_writes", 32'(writes_row), 32'(H_VISIBLE));
        chk("row_done_count", 32'(done_count), 32'(done_before + 1));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit seen;
        reset         = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_y     = '0;
        repeat (3) step();
        chk("reset_row_ready", 32'(bus.row_ready), 32'd1);
        chk("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset_row_done", 32'(bus.row_done), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_err", 32'(bus.err_spurious), 32'd0);
        chk("reset_dir_x", {16'h0, bus.issue_dir_x}, 32'd0);
        reset = 1'b1;
        step();

        // Row 100, latency 3, bank 0, then back-to-back row 7 into bank 1.
        lat = 3;
        start_row(10'd100);
        finish_row(3000, 0);
        chk("lat3_max_outstanding", 32'(max_out), 32'd3);
        start_row(10'd7);
        finish_row(3000, 1);

        // Latency 20 saturates the credit limit.
        lat = 20;
        start_row(10'd479);
        finish_row(5000, 2);
        chk("lat20_max_outstanding", 32'(max_out), 32'(MAX_OUTSTANDING));

        // Random issue_ready stalls.
        lat = 4;
        rand_ready = 1'b1;
        start_row(10'd0);
        finish_row(6000, 3);
        rand_ready = 1'b0;

        // Abort after 200 issues with 5 rays in flight.
        lat       = 5;
        abort_at  = 200;
        flush_res = 0;
        flush_wr  = 0;
        start_row(10'd50);
        for (int i = 0; i < 1000 && !abort_done; i++) step();
        chk("abort_issued", 32'(abort_done), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (bus.row_ready === 1'b1) seen = 1'b1;
        end
        chk("row_ready_after_flush", 32'(seen), 32'd1);
        chk("flush_results_drained", 32'(flush_res), 32'd5);
        chk("flush_pending_empty", 32'(pend_q.size()), 32'd0);
        chk("flush_writes", 32'(flush_wr), 32'd0);
        chk("abort_no_row_done", 32'(done_count), 32'd4);
        chk("abort_handshakes", 32'(hs_row), 32'd200);
        chk("abort_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        flushing = 1'b0;
        abort_at = -1;
        lat      = 3;
        start_row(10'd200);
        finish_row(3000, 4);

        // Spurious result in IDLE.
        force_spur = 1'b1;
        repeat (3) step();
        chk("spurious_err_set", 32'(bus.err_spurious), 32'd1);
        chk("spurious_no_write", 32'(bus.wr_en), 32'd0);
        repeat (4) step();
        chk("spurious_err_sticky", 32'(bus.err_spurious), 32'd1);
        chk("spurious_row_ready", 32'(bus.row_ready), 32'd1);
        reset = 1'b0;
        step();
        chk("err_cleared_by_reset", 32'(bus.err_spurious), 32'd0);
        reset = 1'b1;
        step();
        chk("err_stays_clear", 32'(bus.err_spurious), 32'd0);
        chk("post_reset_row_ready", 32'(bus.row_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ray_row_scheduler.md
Name: ray_row_scheduler

Overview:
Sequences the shared ray_sphere_intersect datapath one display row ahead of the VGA scanout. On a row command it issues one ray per visible pixel, limits in-flight rays with a credit counter, and collects the in-order results. Results go into a ping-pong line buffer that the colour stage reads during the next line. It sits between the VGA timing counters (row commands) and the intersection unit plus line-buffer RAM.

Parameters:
H_VISIBLE, 640, pixels issued per row
H_CENTER, 320, x offset subtracted for ray direction
V_CENTER, 240, y offset for ray direction (inverted)
MAX_OUTSTANDING, 8, max rays in flight in the intersection pipeline
T_W, 16, width of t_value (signed Q8.8)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
row_valid  in  1  row command valid
row_ready  out  1  scheduler can accept a row (high only in IDLE)
row_y  in  10  row index to render
abort  in  1  drop the current row (frame restart)
issue_valid  out  1  ray valid to intersection unit
issue_ready  in  1  intersection unit accepts ray
issue_dir_x  out  16  signed x - H_CENTER
issue_dir_y  out  16  signed V_CENTER - row_y
result_valid  in  1  in-order result from intersection unit (no backpressure)
result_hit  in  1  hit flag
result_t  in  T_W  signed t value
wr_en  out  1  line-buffer write strobe
wr_addr  out  11  {bank, pixel x[9:0]}
wr_data  out  T_W+1  {hit, t}
row_done  out  1  one-cycle pulse when the row is complete
row_done_bank  out  1  bank just completed, valid with row_done
busy  out  1  state != IDLE
err_spurious  out  1  sticky: result_valid arrived with outstanding == 0

Behaviour:
- Reset (reset==0 at a clock edge):
  - State IDLE; x, rx and outstanding = 0; bank = 1, so the first row writes bank 0.
  - All outputs 0 except row_ready = 1.
- States: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - row_ready = 1.
  - On row_valid: latch row_y, toggle bank, clear x and rx, go to ISSUE.
  - First issue_valid appears in the cycle after acceptance.
- ISSUE:
  - issue_valid = (outstanding < MAX_OUTSTANDING).
  - issue_dir_x = x - H_CENTER; issue_dir_y = V_CENTER - y_latched. Both are 16-bit signed and stable while issue_valid && !issue_ready.
  - On handshake: x increments.
  - When x == H_VISIBLE-1 is accepted, go to DRAIN.
- DRAIN:
  - issue_valid = 0.
  - When the final result (rx == H_VISIBLE-1) is written, return to IDLE.
- Outstanding counter:
  - +1 on issue handshake, -1 on result_valid; a simultaneous issue and result leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
  - A result with outstanding == 0 is ignored and sets err_spurious. err_spurious clears only on reset.
- Result capture (ISSUE or DRAIN):
  - result_valid at cycle c produces a registered write at c+1: wr_en = 1, wr_addr = {bank, rx}, wr_data = {result_hit, result_t}.
  - rx increments per result.
- row_done:
  - Asserted for one cycle, in the same cycle as the wr_en of the final pixel.
  - row_done_bank = bank at that time.
  - Next row_ready is high in the following cycle.
- Abort (ISSUE or DRAIN):
  - Next state is FLUSH; issue_valid drops in the next cycle.
  - No row_done is generated.
  - Bank is not toggled back, so the partially written bank is simply overwritten later.
- FLUSH:
  - issue_valid = 0; results arriving here are counted down with no wr_en.
  - Go to IDLE when outstanding reaches 0, or in the same cycle if it is already 0.
- Abort in IDLE has no effect. If abort and row_valid arrive together in IDLE, the row is accepted.
- Reset mid-row: immediate return to IDLE. In-flight results from the datapath are the responsibility of the datapath reset.

Decomposition:
- Shared package ray_pkg holds:
  - sched_state_t enum (IDLE, ISSUE, DRAIN, FLUSH)
  - H_VISIBLE and H_CENTER/V_CENTER constants
  - Q8.8 typedef for t
  - line-buffer entry struct {hit, t}
- One sub-module, ray_credit_counter, implements the outstanding up/down counter with full and empty flags. Everything else stays flat.

Test Plan:
- Row with row_y = 100, issue_ready tied 1, result_valid 3 cycles after each issue.
  - Exactly 640 handshakes; first issue_dir_x = -320, last = 319; issue_dir_y = 140.
  - 640 writes to addresses 0..639 of bank 0; one row_done with row_done_bank = 0.
- Two back-to-back rows: the second row writes addresses 1024..1663 (bank 1), and its row_done_bank = 1.
- Result latency 20 with MAX_OUTSTANDING = 8: outstanding never exceeds 8; issue_valid deasserts while outstanding == 8; all 640 results are still written in order.
- issue_ready toggled pseudo-randomly: issue_dir_x is held stable during stalls, and no pixel is skipped or duplicated.
- Abort after 200 issues with 5 rays in flight:
  - No row_done; zero writes during FLUSH.
  - row_ready returns once the 5 remaining results have arrived.
  - The next row completes cleanly.
- result_valid pulsed in IDLE: no wr_en and err_spurious = 1; err_spurious clears only after reset = 0 for one cycle.
